// File: rtl/core_scheduler.sv
// Purpose: sequences three cores: loads each core's RAM from a shared source RAM, releases it, waits for done or timeout.
// Latency: first src_addr in the cycle after start; each core write lands one cycle after its source address.
// Backpressure: none; start is ignored while busy, and a core that never finishes is aborted after TIMEOUT RUN cycles.
//
// Ports:
//   clk, reset                     - single clock, asynchronous active-high reset
//   start                          - begin the three-core sequence (sampled in IDLE only)
//   src_addr / src_data            - shared source RAM read port (data valid one cycle after address)
//   core_we / core_waddr / core_wdata - one-hot write port into the selected core's data RAM
//   core_init / core_done          - per-core hold-in-reset and completion (bit0 = core 1)
//   busy, all_done, timeout_flags, cur_core - status
module core_scheduler #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] src_addr,
    input  logic [7:0] src_data,
    output logic [2:0] core_we,
    output logic [7:0] core_waddr,
    output logic [7:0] core_wdata,
    output logic [2:0] core_init,
    input  logic [2:0] core_done,
    output logic       busy,
    output logic       all_done,
    output logic [2:0] timeout_flags,
    output logic [1:0] cur_core
);

    // Wide enough to hold TIMEOUT-1 without wrapping.
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REL,
        RUN,
        NEXT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [6:0]    idx;         // position within the current core's load list
    logic [CW-1:0] cnt;         // RUN cycle counter
    logic          wr_pend;     // a source read was issued last cycle
    logic [7:0]    wr_addr;     // address of that read, reused as the core write address
    logic [2:0]    core_sel;
    logic [7:0]    list_addr;
    logic [6:0]    last_idx;
    logic          run_done;
    logic          run_to;

    always_comb begin
        core_sel = 3'b000;
        case (cur_core)
            2'd1:    core_sel = 3'b001;
            2'd2:    core_sel = 3'b010;
            2'd3:    core_sel = 3'b100;
            default: core_sel = 3'b000;
        endcase
    end

    // Load lists: core 1 = 1..3, core 2 = 6 then 32..95, core 3 = 128..147.
    always_comb begin
        list_addr = 8'd0;
        last_idx  = 7'd0;
        case (cur_core)
            2'd1: begin
                list_addr = 8'd1 + 8'(idx);
                last_idx  = 7'd2;
            end
            2'd2: begin
                list_addr = (idx == 7'd0) ? 8'd6 : 8'd31 + 8'(idx);
                last_idx  = 7'd64;
            end
            2'd3: begin
                list_addr = 8'd128 + 8'(idx);
                last_idx  = 7'd19;
            end
            default: begin
                list_addr = 8'd0;
                last_idx  = 7'd0;
            end
        endcase
    end

    // done is ignored on the first RUN cycle (cnt == 0); done on the final
    // counted cycle takes priority over the timeout.
    always_comb begin
        run_done = (cnt != '0) && ((core_done & core_sel) != 3'b000);
        run_to   = !run_done && (cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            // The last address is issued here; its write lands during REL.
            LOAD: if (idx == last_idx) state_nxt = REL;
            REL:  state_nxt = RUN;
            RUN:  if (run_done || run_to) state_nxt = NEXT;
            NEXT: state_nxt = (cur_core == 2'd3) ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_core      <= 2'd0;
            idx           <= 7'd0;
            cnt           <= '0;
            wr_pend       <= 1'b0;
            wr_addr       <= 8'd0;
            all_done      <= 1'b0;
            timeout_flags <= 3'b000;
        end else begin
            wr_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        all_done      <= 1'b0;
                        timeout_flags <= 3'b000;
                        cur_core      <= 2'd1;
                        idx           <= 7'd0;
                    end
                end
                LOAD: begin
                    wr_pend <= 1'b1;
                    wr_addr <= list_addr;
                    idx     <= (idx == last_idx) ? 7'd0 : idx + 7'd1;
                end
                REL: begin
                    cnt <= '0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (run_to) timeout_flags <= timeout_flags | core_sel;
                end
                NEXT: begin
                    idx <= 7'd0;
                    if (cur_core == 2'd3) begin
                        cur_core <= 2'd0;
                        all_done <= 1'b1;
                    end else begin
                        cur_core <= cur_core + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign src_addr   = (state == LOAD) ? list_addr : 8'd0;
    assign core_init  = ((state == LOAD) || (state == REL)) ? core_sel : 3'b000;
    assign core_we    = wr_pend ? core_sel : 3'b000;
    assign core_waddr = wr_pend ? wr_addr : 8'd0;
    assign core_wdata = wr_pend ? src_data : 8'd0;

endmodule

// File: tb/tb_core_scheduler.sv
// Testbench for core_scheduler: directed sequences with a source RAM model (data = addr ^ 8'h5A).
module tb_core_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] src_data;
    logic [2:0] core_we;
    logic [7:0] core_waddr;
    logic [7:0] core_wdata;
    logic [2:0] core_init;
    logic [2:0] core_done;
    logic       busy;
    logic       all_done;
    logic [2:0] timeout_flags;
    logic [1:0] cur_core;

    int checks   = 0;
    int failures = 0;
    int nwr      = 0;
    int widx [3] = '{0, 0, 0};
    int cyc;
    int nwr0;
    bit ok;

    core_scheduler #(.TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src_addr(src_addr),
        .src_data(src_data),
        .core_we(core_we),
        .core_waddr(core_waddr),
        .core_wdata(core_wdata),
        .core_init(core_init),
        .core_done(core_done),
        .busy(busy),
        .all_done(all_done),
        .timeout_flags(timeout_flags),
        .cur_core(cur_core)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM: one-cycle read latency.
    always @(posedge clk) src_data <= src_addr ^ 8'h5A;

    function automatic logic [7:0] exp_addr(input int c, input int i);
        if (c == 0) return 8'(1 + i);
        if (c == 1) return (i == 0) ? 8'd6 : 8'(31 + i);
        return 8'(128 + i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check any core write seen there.
    task automatic tick();
        int c;
        @(negedge clk);
        for (int k = 0; k < 3; k++) if (!core_init[k]) widx[k] = 0;
        if (core_we != 3'b000) begin
            c = (core_we == 3'b001) ? 0 : (core_we == 3'b010) ? 1 : (core_we == 3'b100) ? 2 : -1;
            chk("we_onehot", {31'd0, c >= 0}, 32'd1);
            if (c >= 0) begin
                chk("we_core_in_init", {31'd0, core_init[c]}, 32'd1);
                chk("waddr", {24'd0, core_waddr}, {24'd0, exp_addr(c, widx[c])});
                chk("wdata", {24'd0, core_wdata}, {24'd0, exp_addr(c, widx[c]) ^ 8'h5A});
                widx[c]++;
            end
            nwr++;
        end
    endtask

    // Leaves the bench on the first RUN cycle of core c.
    task automatic wait_run(input int c, output bit found);
        int n = 0;
        while (!core_init[c] && n < 300) begin tick(); n++; end
        while (core_init[c] && n < 300) begin tick(); n++; end
        found = (n < 300);
    endtask

    // From RUN cycle 0, drive done from RUN cycle done_at on (-1 = never) and
    // count cycles until the next core starts loading or the sequence ends.
    task automatic do_run(input int c, input int done_at, output int cycles);
        bit ended = 0;
        cycles = 0;
        while (!ended && cycles < 200) begin
            core_done[c] = (done_at >= 0) && (cycles >= done_at);
            tick();
            cycles++;
            if (c < 2) ended = core_init[c + 1];
            else       ended = !busy;
        end
        core_done[c] = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        core_done = 3'b000;

        // Reset state
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {29'd0, core_we}, 32'd0);
        chk("rst_init", {29'd0, core_init}, 32'd0);
        chk("rst_src_addr", {24'd0, src_addr}, 32'd0);
        chk("rst_cur_core", {30'd0, cur_core}, 32'd0);
        chk("rst_all_done", {31'd0, all_done}, 32'd0);
        chk("rst_flags", {29'd0, timeout_flags}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Sequence 1: every core done on its 5th RUN cycle
        nwr0  = nwr;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_busy", {31'd0, busy}, 32'd1);
        chk("s1_cur_core", {30'd0, cur_core}, 32'd1);
        chk("s1_src0", {24'd0, src_addr}, 32'd1);
        chk("s1_init0", {29'd0, core_init}, 32'd1);
        chk("s1_we0", {29'd0, core_we}, 32'd0);
        tick();
        chk("s1_src1", {24'd0, src_addr}, 32'd2);
        chk("s1_we1", {29'd0, core_we}, 32'd1);
        chk("s1_waddr1", {24'd0, core_waddr}, 32'd1);
        chk("s1_wdata1", {24'd0, core_wdata}, 32'h5B);
        tick();
        chk("s1_src2", {24'd0, src_addr}, 32'd3);
        tick();
        chk("s1_rel_we", {29'd0, core_we}, 32'd1);
        chk("s1_rel_waddr", {24'd0, core_waddr}, 32'd3);
        chk("s1_rel_init", {29'd0, core_init}, 32'd1);
        tick();
        chk("s1_run_init", {29'd0, core_init}, 32'd0);
        chk("s1_run_we", {29'd0, core_we}, 32'd0);
        do_run(0, 4, cyc);
        chk("s1_run1_cycles", cyc, 32'd6);
        chk("s1_c2_src0", {24'd0, src_addr}, 32'd6);
        chk("s1_c2_cur", {30'd0, cur_core}, 32'd2);
        tick();
        chk("s1_c2_src32", {24'd0, src_addr}, 32'd32);
        tick();
        chk("s1_c2_we32", {29'd0, core_we}, 32'b010);
        chk("s1_c2_waddr32", {24'd0, core_waddr}, 32'd32);
        chk("s1_c2_wdata32", {24'd0, core_wdata}, 32'h7A);
        wait_run(1, ok);
        chk("s1_wait2", {31'd0, ok}, 32'd1);
        do_run(1, 4, cyc);
        chk("s1_run2_cycles", cyc, 32'd6);
        wait_run(2, ok);
        chk("s1_wait3", {31'd0, ok}, 32'd1);
        do_run(2, 4, cyc);
        chk("s1_run3_cycles", cyc, 32'd6);
        chk("s1_end_busy", {31'd0, busy}, 32'd0);
        chk("s1_all_done", {31'd0, all_done}, 32'd1);
        chk("s1_flags", {29'd0, timeout_flags}, 32'd0);
        chk("s1_cur_core_end", {30'd0, cur_core}, 32'd0);
        chk("s1_writes", nwr - nwr0, 32'd88);

        // Sequence 2: core 1 done held from the start, core 2 times out,
        // start pulsed during core 3 load
        nwr0      = nwr;
        core_done = 3'b001;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("s2_clear_all_done", {31'd0, all_done}, 32'd0);
        wait_run(0, ok);
        chk("s2_wait1", {31'd0, ok}, 32'd1);
        chk("s2_c1_writes", nwr - nwr0, 32'd3);
        do_run(0, 0, cyc);
        chk("s2_run1_cycles", cyc, 32'd3);
        wait_run(1, ok);
        chk("s2_wait2", {31'd0, ok}, 32'd1);
        do_run(1, -1, cyc);
        chk("s2_run2_timeout_cycles", cyc, 32'd17);
        chk("s2_flags_mid", {29'd0, timeout_flags}, 32'b010);
        chk("s2_c3_cur", {30'd0, cur_core}, 32'd3);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("s2_start_ignored_cur", {30'd0, cur_core}, 32'd3);
        chk("s2_start_ignored_init", {29'd0, core_init}, 32'b100);
        chk("s2_start_ignored_src", {24'd0, src_addr}, 32'd130);
        wait_run(2, ok);
        chk("s2_wait3", {31'd0, ok}, 32'd1);
        do_run(2, 4, cyc);
        chk("s2_run3_cycles", cyc, 32'd6);
        chk("s2_flags", {29'd0, timeout_flags}, 32'b010);
        chk("s2_all_done", {31'd0, all_done}, 32'd1);
        chk("s2_writes", nwr - nwr0, 32'd88);

        // Sequence 3: reset in the middle of core 2 load
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s3_flags_cleared", {29'd0, timeout_flags}, 32'd0);
        chk("s3_all_done_cleared", {31'd0, all_done}, 32'd0);
        wait_run(0, ok);
        chk("s3_wait1", {31'd0, ok}, 32'd1);
        do_run(0, 4, cyc);
        chk("s3_run1_cycles", cyc, 32'd6);
        tick();
        tick();
        tick();
        chk("s3_loading", {29'd0, core_we}, 32'b010);
        nwr0 = nwr;
        #2 reset = 1'b1;
        #1;
        chk("s3_rst_busy", {31'd0, busy}, 32'd0);
        chk("s3_rst_we", {29'd0, core_we}, 32'd0);
        chk("s3_rst_init", {29'd0, core_init}, 32'd0);
        chk("s3_rst_src", {24'd0, src_addr}, 32'd0);
        chk("s3_rst_waddr", {24'd0, core_waddr}, 32'd0);
        chk("s3_rst_wdata", {24'd0, core_wdata}, 32'd0);
        chk("s3_rst_cur", {30'd0, cur_core}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("s3_no_writes", nwr - nwr0, 32'd0);
        chk("s3_idle", {31'd0, busy}, 32'd0);
        chk("s3_all_done", {31'd0, all_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, max RUN cycles allowed per core before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to run the full three-core sequence; sampled in IDLE only.
REQ-005 SHALL have port src_addr  output  8  read address into shared source data RAM.
REQ-006 SHALL have port src_data  input  8  source RAM read data, valid one cycle after src_addr.
REQ-007 SHALL have port core_we  output  3  one-hot write enable; bit0 = core 1, bit1 = core 2, bit2 = core 3.
REQ-008 SHALL have port core_waddr  output  8  write address to the selected core's data RAM.
REQ-009 SHALL have port core_wdata  output  8  write data to the selected core's data RAM.
REQ-010 SHALL have port core_init  output  3  per-core init (hold-in-reset); same bit mapping as core_we.
REQ-011 SHALL have port core_done  input  3  per-core done; same bit mapping.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port all_done  output  1  high in IDLE after a completed sequence.
REQ-014 SHALL have port timeout_flags  output  3  sticky per-core timeout record for the last sequence.
REQ-015 SHALL have port cur_core  output  2  core being serviced (1..3); 0 in IDLE.

Function
REQ-016 SHALL implement states IDLE, LOAD, REL, RUN, NEXT.
REQ-017 SHALL, in IDLE with start high, clear all_done and timeout_flags, set cur_core=1, and enter LOAD next cycle.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL use load address lists: core 1 = 1,2,3; core 2 = 6 then 32..95; core 3 = 128..147 (lengths 3, 65, 20).
REQ-020 SHALL, in LOAD, issue one src_addr per cycle in list order, starting the first LOAD cycle.
REQ-021 SHALL, one cycle after each issued address, pulse core_we[cur_core-1] with core_waddr = that address and core_wdata = src_data.
REQ-022 SHALL hold core_we=0 whenever no write is pending; no write to a core other than cur_core.
REQ-023 SHALL hold core_init[cur_core-1] high from the first LOAD cycle through REL; other core_init bits low.
REQ-024 SHALL enter REL in the cycle the last write is issued and stay there exactly one cycle, then enter RUN with core_init all low.
REQ-025 SHALL, in RUN, count cycles from 0 and ignore core_done in the first RUN cycle.
REQ-026 SHALL, from the second RUN cycle, enter NEXT when core_done[cur_core-1] is high.
REQ-027 SHALL set timeout_flags[cur_core-1] and enter NEXT when the counter reaches TIMEOUT-1 without done; done in that same cycle wins (no flag).
REQ-028 SHALL, in NEXT (one cycle), increment cur_core and go to LOAD, or if cur_core was 3 go to IDLE with all_done=1, cur_core=0.
REQ-029 SHALL size the RUN counter to hold TIMEOUT-1 without wrap.

Reset
REQ-030 SHALL, on reset assertion regardless of clock, force IDLE, busy=0, all_done=0, timeout_flags=0, cur_core=0, core_we=0, core_init=0, src_addr=0, core_waddr=0, core_wdata=0, counters=0.
REQ-031 SHALL abort a sequence in progress on reset with no further writes and no restart until a new start after reset release.

Verification
REQ-032 SHALL cover: reset then start, all cores done 5 cycles into RUN -> 88 writes total with correct addresses/data, all_done=1, timeout_flags=000.
REQ-033 SHALL cover: source RAM at address a = a^8'h5A -> core 2 writes address 32 with data 8'h7A one cycle after src_addr=32.
REQ-034 SHALL cover: core 2 never asserts done, TIMEOUT=16 -> 16 RUN cycles for core 2, timeout_flags=010, core 3 still loaded and run.
REQ-035 SHALL cover: core_done[0] held high during LOAD and REL of core 1 -> ignored; NEXT only from second RUN cycle.
REQ-036 SHALL cover: start pulsed mid-LOAD of core 3 -> no effect; reset mid-LOAD of core 2 -> all outputs zero immediately, no further core_we pulses.
